// File: rtl/store_buffer_pkg.sv
// Shared memory-control encodings, alignment helpers and the store-buffer entry layout.
package store_buffer_pkg;

  typedef enum logic [3:0] {
    MEM_LW  = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LBU = 4'd3,
    MEM_LHU = 4'd4,
    MEM_SW  = 4'd5,
    MEM_SH  = 4'd6,
    MEM_SB  = 4'd7
  } mem_ctrl_e;

  localparam logic [1:0] ALIGN_MASK_W = 2'b11;
  localparam logic [1:0] ALIGN_MASK_H = 2'b01;
  localparam logic [1:0] ALIGN_MASK_B = 2'b00;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ctrl;
  } sb_entry_t;

  function automatic logic is_store(input logic [3:0] ctrl);
    case (ctrl)
      MEM_SW, MEM_SH, MEM_SB: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_mask(input logic [3:0] ctrl);
    case (ctrl)
      MEM_LW, MEM_SW:          align_mask = ALIGN_MASK_W;
      MEM_LH, MEM_LHU, MEM_SH: align_mask = ALIGN_MASK_H;
      default:                 align_mask = ALIGN_MASK_B;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [3:0] ctrl, input logic [1:0] addr_lo);
    is_aligned = ((addr_lo & align_mask(ctrl)) == 2'b00);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Request-side and memory-side signals of the store buffer.
interface store_buffer_if #(parameter int PTR_W = 2);
  logic             req_valid;
  logic             req_we;
  logic [3:0]       req_ctrl;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             req_stall;
  logic             addr_err;
  logic [31:0]      load_data;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_wr;
  logic [3:0]       mem_ctrl;
  logic [31:0]      mem_rdata;
  logic             buf_empty;
  logic [PTR_W:0]   buf_count;

  modport master (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
    input  req_stall, addr_err, load_data, mem_addr, mem_wdata, mem_wr, mem_ctrl,
           buf_empty, buf_count
  );

  modport slave (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
    output req_stall, addr_err, load_data, mem_addr, mem_wdata, mem_wr, mem_ctrl,
           buf_empty, buf_count
  );
endinterface

// File: rtl/store_buffer_sb_fifo_ram.sv
// Entry storage for the store buffer: write at tail, read at head, and a
// per-entry word-address match vector used for load hazard detection.
module sb_fifo_ram
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  sb_entry_t        wr_entry,
  input  logic [PTR_W-1:0] rd_ptr,
  output sb_entry_t        rd_entry,
  input  logic [29:0]      cmp_word,
  output logic [DEPTH-1:0] hit_vec
);

  sb_entry_t entry_r [DEPTH];

  // Capture the accepted store at the tail slot; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_r[wr_ptr] <= wr_entry;
    end
  end

  assign rd_entry = entry_r[rd_ptr];

  // Word-granular compare of every slot; occupancy is masked by the caller.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = (entry_r[i].addr[31:2] == cmp_word);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: stores queue and retire when the port is idle, loads
// use the port directly and stall while a pending store covers their word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  store_buffer_if.slave   bus
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_r, tail_r;
  logic [PTR_W:0]   count_r;
  sb_entry_t        wr_entry_s, rd_entry_s;
  logic [DEPTH-1:0] hit_vec_s, occ_vec_s;
  logic             aligned_s, load_req_s, store_req_s, load_hit_s;
  logic             load_acc_s, drain_s, store_acc_s;
  logic [31:0]      mem_addr_s, mem_wdata_s;
  logic [3:0]       mem_ctrl_s;
  logic             mem_wr_s;

  assign wr_entry_s = '{addr: bus.req_addr, data: bus.req_wdata, ctrl: bus.req_ctrl};

  sb_fifo_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk      (clk),
    .wr_en    (store_acc_s),
    .wr_ptr   (tail_r),
    .wr_entry (wr_entry_s),
    .rd_ptr   (head_r),
    .rd_entry (rd_entry_s),
    .cmp_word (bus.req_addr[31:2]),
    .hit_vec  (hit_vec_s)
  );

  // Slot i is occupied when its distance from head is below the count.
  always_comb begin
    logic [PTR_W-1:0] off_v;
    off_v     = '0;
    occ_vec_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_v        = PTR_W'(i) - head_r;
      occ_vec_s[i] = ({1'b0, off_v} < count_r);
    end
  end

  assign aligned_s   = is_aligned(bus.req_ctrl, bus.req_addr[1:0]);
  assign load_req_s  = bus.req_valid && aligned_s && !bus.req_we;
  assign store_req_s = bus.req_valid && aligned_s && bus.req_we;
  assign load_hit_s  = |(hit_vec_s & occ_vec_s);
  assign load_acc_s  = load_req_s && !load_hit_s;
  assign drain_s     = !load_acc_s && (count_r != '0);
  assign store_acc_s = store_req_s && ((count_r < DEPTH_C) || drain_s);

  // Single memory port: accepted load first, then head drain, else idle.
  always_comb begin
    mem_addr_s  = bus.req_addr;
    mem_wdata_s = bus.req_wdata;
    mem_ctrl_s  = bus.req_ctrl;
    mem_wr_s    = 1'b0;
    if (load_acc_s) begin
      mem_addr_s = bus.req_addr;
      mem_ctrl_s = bus.req_ctrl;
    end else if (drain_s) begin
      mem_addr_s  = rd_entry_s.addr;
      mem_wdata_s = rd_entry_s.data;
      mem_ctrl_s  = rd_entry_s.ctrl;
      mem_wr_s    = 1'b1;
    end else begin
      mem_wr_s = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping; a reset drops any pending stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (drain_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      if (store_acc_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      case ({store_acc_s, drain_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.req_stall = (load_req_s && load_hit_s) || (store_req_s && !store_acc_s);
  assign bus.addr_err  = bus.req_valid && !aligned_s;
  assign bus.load_data = bus.mem_rdata;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.mem_ctrl  = mem_ctrl_s;
  assign bus.mem_wr    = mem_wr_s;
  assign bus.buf_empty = (count_r == '0);
  assign bus.buf_count = count_r;

endmodule
